// File: rtl/smi_pkg.sv
// Shared SMI types and helpers: EOFC encoding, clog2, flit/frame sizing.
// Latency: none (package only).
// Backpressure: not applicable.
package smi_pkg;

  // EOFC value carried by every flit except the last one of a frame
  localparam logic [7:0] EOFC_NOT_LAST = 8'd0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } smiTxState_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bits in one flit of flitWidth bytes
  function automatic int flitBits(input int flitWidth);
    return flitWidth * 8;
  endfunction

  // Largest frame in bytes that fits in maxFrameFlits flits
  function automatic int frameBytes(input int flitWidth, input int maxFrameFlits);
    return flitWidth * maxFrameFlits;
  endfunction

endpackage

// File: rtl/smi_flit_select.sv
// Picks one flit out of a frame register and zeroes bytes past the last-flit EOFC.
// Latency: purely combinational.
// Backpressure: none; caller holds flitIdx/isLast stable while its output is stalled.
module smi_flit_select
  import smi_pkg::*;
#(
  parameter int FlitWidth     = 8,
  parameter int MaxFrameFlits = 16,
  parameter int FlitCountSize = clog2(MaxFrameFlits) + 1
) (
  input  logic [FlitWidth*8*MaxFrameFlits-1:0] frame,
  input  logic [FlitCountSize-1:0]             flitIdx,
  input  logic                                 isLast,
  input  logic [7:0]                           lastBytes,
  output logic [FlitWidth*8-1:0]               flit
);

  localparam int FlitBits = flitBits(FlitWidth);

  logic [FlitBits-1:0] rawFlit;

  assign rawFlit = frame[int'(flitIdx)*FlitBits +: FlitBits];

  // Pass bytes through, except bytes of the last flit beyond its valid count
  always_comb begin
    flit = '0;
    for (int b = 0; b < FlitWidth; b++) begin
      if (isLast && (b >= int'(lastBytes))) begin
        flit[b*8 +: 8] = 8'h00;
      end else begin
        flit[b*8 +: 8] = rawFlit[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/smi_frame_disassembler.sv
// Serialises one wide SMI frame per handshake into a valid/EOFC/stop flit stream.
// Latency: first flit valid 1 clk after accept; back-to-back frames with no bubble.
// Backpressure: dataOutStop freezes the output flit; frameInStop is low only when idle or the last flit is taken.
module smi_frame_disassembler
  import smi_pkg::*;
#(
  parameter int FlitWidth     = 8,
  parameter int MaxFrameFlits = 16,
  parameter int LengthSize    = 8,
  parameter int FlitCountSize = clog2(MaxFrameFlits) + 1
) (
  input  logic                                 clk,
  input  logic                                 arstn,
  input  logic                                 frameInValid,
  input  logic [LengthSize-1:0]                frameInLength,
  input  logic [FlitWidth*8*MaxFrameFlits-1:0] frameInData,
  output logic                                 frameInStop,
  output logic                                 dataOutValid,
  output logic [7:0]                           dataOutEofc,
  output logic [FlitWidth*8-1:0]               dataOut,
  input  logic                                 dataOutStop
);

  localparam int FlitBits  = flitBits(FlitWidth);
  localparam int FrameBits = FlitBits * MaxFrameFlits;
  localparam int MaxLength = frameBytes(FlitWidth, MaxFrameFlits);
  localparam int FlitShift = clog2(FlitWidth);

  localparam logic [LengthSize-1:0] MaxLengthL = LengthSize'(MaxLength);
  localparam logic [LengthSize-1:0] ByteMask   = LengthSize'(FlitWidth - 1);
  localparam logic [LengthSize-1:0] LenOne     = LengthSize'(1);

  smiTxState_e state, stateNext;

  logic                     ready;
  logic [FrameBits-1:0]     frameReg;
  logic [FlitCountSize-1:0] idx;
  logic [FlitCountSize-1:0] lastIdx;
  logic [7:0]               lastEofc;

  logic [LengthSize-1:0]    lenClamped;
  logic [LengthSize-1:0]    lenMinus1;
  logic [FlitCountSize-1:0] newLastIdx;
  logic [7:0]               newLastEofc;
  logic                     lenNonZero;
  logic                     sending;
  logic                     lastFlit;
  logic                     accept;
  logic                     loadFrame;
  logic                     advance;
  logic [FlitBits-1:0]      flitSel;

  // Length decode: clamp, then last-flit index and last-flit byte count.
  // Only meaningful when the length is non-zero; zero-length frames are dropped.
  assign lenClamped  = (frameInLength > MaxLengthL) ? MaxLengthL : frameInLength;
  assign lenMinus1   = lenClamped - LenOne;
  assign newLastIdx  = FlitCountSize'(lenMinus1 >> FlitShift);
  assign newLastEofc = 8'((lenMinus1 & ByteMask) + LenOne);
  assign lenNonZero  = |frameInLength;

  assign sending  = (state == SEND);
  assign lastFlit = (idx == lastIdx);

  // In SEND the input opens only as the last flit leaves, so the next frame
  // follows without a bubble. In IDLE it opens one edge after reset release.
  assign frameInStop = sending ? ~(lastFlit & ~dataOutStop) : ~ready;
  assign accept      = frameInValid & ~frameInStop;

  smi_flit_select #(
    .FlitWidth     (FlitWidth),
    .MaxFrameFlits (MaxFrameFlits),
    .FlitCountSize (FlitCountSize)
  ) uFlitSelect (
    .frame     (frameReg),
    .flitIdx   (idx),
    .isLast    (lastFlit),
    .lastBytes (lastEofc),
    .flit      (flitSel)
  );

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, datapath strobes and flit outputs
  always_comb begin
    stateNext    = state;
    loadFrame    = 1'b0;
    advance      = 1'b0;
    dataOutValid = sending;
    dataOutEofc  = EOFC_NOT_LAST;
    dataOut      = '0;
    case (state)
      IDLE: begin
        if (accept && lenNonZero) begin
          loadFrame = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        dataOut = flitSel;
        if (lastFlit) begin
          dataOutEofc = lastEofc;
        end
        if (!dataOutStop) begin
          if (lastFlit) begin
            if (accept && lenNonZero) begin
              loadFrame = 1'b1;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Frame capture and flit index; everything holds while the output is stalled
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      frameReg <= '0;
      idx      <= '0;
      lastIdx  <= '0;
      lastEofc <= '0;
    end else if (loadFrame) begin
      frameReg <= frameInData;
      idx      <= '0;
      lastIdx  <= newLastIdx;
      lastEofc <= newLastEofc;
    end else if (advance) begin
      idx <= idx + FlitCountSize'(1);
    end
  end

  // Holds the input closed for the first edge after reset release
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

endmodule
